sorting_kv: RTL and testbench

- Packet sorter, next generation of the single-mode sorter.
- Accepts one sop/eop-framed packet of up to 2**AWIDTH words and stores it in on-chip RAM.
- Sorts the words by a key field (ascending or descending, selected per packet), stably, then streams the sorted packet out under ready/valid backpressure.
- Sits between a packet source and any downstream consumer that may stall.

---
 rtl/sorting_kv.sv | 262 ++++++++++++++++++++++++++
 tb/tb_sorting_kv.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sorting_kv.sv
// ---------------------------------------------------------------------------
// sorting_kv
//   Packet sorter. Captures one sop/eop framed packet of up to 2**AWIDTH words
//   into a local RAM. It sorts the words stably by the key field in the top
//   KWIDTH bits, in ascending or descending order chosen per packet. It then
//   streams the sorted packet out under ready/valid flow control.
//
// Ports
//   clk_i    : clock, everything on the rising edge
//   arst_i   : asynchronous active-high reset
//   data_i   : input word {key, payload}
//   sop_i    : first input word of a packet
//   eop_i    : last input word of a packet
//   val_i    : input word valid (no input backpressure)
//   desc_i   : sort order taken with the sop beat, 1 = descending
//   data_o   : sorted output word
//   sop_o    : first sorted word
//   eop_o    : last sorted word
//   val_o    : output word valid
//   ready_i  : downstream accepts the current output word
//   busy_o   : sorting or emitting, input ignored while high
//   ovf_o    : one-cycle pulse when a packet was cut at 2**AWIDTH words
// ---------------------------------------------------------------------------
module sorting_kv #(
  parameter int DWIDTH = 32,
  parameter int KWIDTH = 16,
  parameter int AWIDTH = 8
) (
  input  logic              clk_i,
  input  logic              arst_i,
  input  logic [DWIDTH-1:0] data_i,
  input  logic              sop_i,
  input  logic              eop_i,
  input  logic              val_i,
  input  logic              desc_i,
  output logic [DWIDTH-1:0] data_o,
  output logic              sop_o,
  output logic              eop_o,
  output logic              val_o,
  input  logic              ready_i,
  output logic              busy_o,
  output logic              ovf_o
);

  localparam int DEPTH = 1 << AWIDTH;
  localparam logic [AWIDTH-1:0] A_ONE  = AWIDTH'(1);
  localparam logic [AWIDTH-1:0] A_ZERO = AWIDTH'(0);
  localparam logic [AWIDTH:0]   C_ONE  = (AWIDTH+1)'(1);
  localparam logic [AWIDTH:0]   C_ZERO = (AWIDTH+1)'(0);
  localparam logic [AWIDTH:0]   C_LAST = (AWIDTH+1)'(DEPTH-1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SORT_START,
    S_SORT_CMP,
    S_SORT_LAST,
    S_OUT
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [DWIDTH-1:0] r_mem [DEPTH];

  // r_cnt counts the words stored. Once loading ends it holds the packet length.
  logic [AWIDTH:0]   r_cnt;
  logic              r_desc;
  logic [DWIDTH-1:0] r_carry;
  logic [AWIDTH-1:0] r_j;
  logic [AWIDTH-1:0] r_passEnd;
  logic              r_swapped;
  logic [AWIDTH:0]   r_rdAddr;
  logic              r_ovf;
  logic [DWIDTH-1:0] r_dataOut;
  logic              r_sopOut;
  logic              r_eopOut;
  logic              r_valOut;

  logic              w_we;
  logic [AWIDTH-1:0] w_waddr;
  logic [DWIDTH-1:0] w_wdata;
  logic [DWIDTH-1:0] w_cur;
  logic [KWIDTH-1:0] w_keyCarry;
  logic [KWIDTH-1:0] w_keyCur;
  logic              w_swap;
  logic              w_full;
  logic              w_outLoad;

  // The bubble pass carries the current largest word (in sort order) in
  // r_carry. Only a strict key compare allows a swap, so equal keys keep
  // their input order. This keeps the sort stable in both directions.
  assign w_cur      = r_mem[r_j];
  assign w_keyCarry = r_carry[DWIDTH-1 -: KWIDTH];
  assign w_keyCur   = w_cur[DWIDTH-1 -: KWIDTH];
  assign w_swap     = r_desc ? (w_keyCarry < w_keyCur) : (w_keyCarry > w_keyCur);
  assign w_full     = (r_cnt == C_LAST);
  assign w_outLoad  = !r_valOut || ready_i;

  assign data_o = r_dataOut;
  assign sop_o  = r_sopOut;
  assign eop_o  = r_eopOut;
  assign val_o  = r_valOut;
  assign ovf_o  = r_ovf;
  assign busy_o = (r_state != S_IDLE) && (r_state != S_LOAD);

  // State register.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic and the single RAM write port. The write port is shared
  // by packet loading and the sort passes.
  always_comb begin
    w_next  = r_state;
    w_we    = 1'b0;
    w_waddr = A_ZERO;
    w_wdata = data_i;
    case (r_state)
      S_IDLE: begin
        if (val_i && sop_i) begin
          w_we   = 1'b1;
          w_next = eop_i ? S_SORT_START : S_LOAD;
        end
      end
      S_LOAD: begin
        if (val_i) begin
          w_we = 1'b1;
          if (sop_i && !eop_i) begin
            w_waddr = A_ZERO;
          end else begin
            w_waddr = r_cnt[AWIDTH-1:0];
            if (eop_i || w_full) begin
              w_next = S_SORT_START;
            end
          end
        end
      end
      S_SORT_START: begin
        w_next = (r_cnt == C_ONE) ? S_OUT : S_SORT_CMP;
      end
      S_SORT_CMP: begin
        w_we    = 1'b1;
        w_waddr = r_j - A_ONE;
        w_wdata = w_swap ? w_cur : r_carry;
        if (r_j == r_passEnd) begin
          w_next = S_SORT_LAST;
        end
      end
      S_SORT_LAST: begin
        w_we    = 1'b1;
        w_waddr = r_passEnd;
        w_wdata = r_carry;
        if (!r_swapped || (r_passEnd == A_ONE)) begin
          w_next = S_OUT;
        end else begin
          w_next = S_SORT_START;
        end
      end
      S_OUT: begin
        if (r_valOut && ready_i && r_eopOut) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Packet RAM. It has no reset, so its contents survive arst_i.
  always_ff @(posedge clk_i) begin
    if (w_we) begin
      r_mem[w_waddr] <= w_wdata;
    end
  end

  // Datapath. Each sort pass puts its last element in its final place, so
  // the next pass ends one address earlier. Sorting stops after a pass with
  // no swaps. The output register is refilled straight from the RAM whenever
  // it is empty or being accepted, so a ready consumer sees one word per clock.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      r_cnt     <= C_ZERO;
      r_desc    <= 1'b0;
      r_carry   <= '0;
      r_j       <= A_ZERO;
      r_passEnd <= A_ZERO;
      r_swapped <= 1'b0;
      r_rdAddr  <= C_ZERO;
      r_ovf     <= 1'b0;
      r_dataOut <= '0;
      r_sopOut  <= 1'b0;
      r_eopOut  <= 1'b0;
      r_valOut  <= 1'b0;
    end else begin
      r_ovf <= 1'b0;
      if (r_state != S_OUT) begin
        r_rdAddr <= C_ZERO;
      end
      case (r_state)
        S_IDLE: begin
          if (val_i && sop_i) begin
            r_desc    <= desc_i;
            r_cnt     <= C_ONE;
            r_passEnd <= A_ZERO;
          end
        end
        S_LOAD: begin
          if (val_i) begin
            if (sop_i && !eop_i) begin
              r_desc <= desc_i;
              r_cnt  <= C_ONE;
            end else begin
              r_cnt     <= r_cnt + C_ONE;
              r_passEnd <= r_cnt[AWIDTH-1:0];
              if (!eop_i && w_full) begin
                r_ovf <= 1'b1;
              end
            end
          end
        end
        S_SORT_START: begin
          r_carry   <= r_mem[A_ZERO];
          r_j       <= A_ONE;
          r_swapped <= 1'b0;
        end
        S_SORT_CMP: begin
          if (!w_swap) begin
            r_carry <= w_cur;
          end
          if (w_swap) begin
            r_swapped <= 1'b1;
          end
          r_j <= r_j + A_ONE;
        end
        S_SORT_LAST: begin
          r_passEnd <= r_passEnd - A_ONE;
        end
        S_OUT: begin
          if (w_outLoad) begin
            if (r_rdAddr < r_cnt) begin
              r_dataOut <= r_mem[r_rdAddr[AWIDTH-1:0]];
              r_valOut  <= 1'b1;
              r_sopOut  <= (r_rdAddr == C_ZERO);
              r_eopOut  <= (r_rdAddr == (r_cnt - C_ONE));
              r_rdAddr  <= r_rdAddr + C_ONE;
            end else begin
              r_valOut <= 1'b0;
              r_sopOut <= 1'b0;
              r_eopOut <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sorting_kv.sv
// ---------------------------------------------------------------------------
// tb_sorting_kv
//   Directed testbench for sorting_kv with DWIDTH=32, KWIDTH=16, AWIDTH=8.
//   Each word is {key[15:0], payload[15:0]}. Expected packets are either
//   written out by hand or produced by a stable insertion sort of the packet
//   that was sent.
// ---------------------------------------------------------------------------
module tb_sorting_kv;

  localparam int DW = 32;
  localparam int KW = 16;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          arst = 1'b0;
  logic [DW-1:0] dataIn = '0;
  logic          sopIn = 1'b0;
  logic          eopIn = 1'b0;
  logic          valIn = 1'b0;
  logic          descIn = 1'b0;
  logic          readyIn;
  logic [DW-1:0] dataOut;
  logic          sopOut, eopOut, valOut, busyOut, ovfOut;

  int total = 0;
  int bad = 0;

  logic [31:0] pktQ[$];
  logic [31:0] expQ[$];
  logic [31:0] rxData[$];
  bit          rxSop[$];
  bit          rxEop[$];
  int          rxCycle[$];
  bit          rxEopSeen = 1'b0;
  int          cycleCnt = 0;
  int          ovfCount = 0;
  bit          rdyRandom = 1'b0;
  bit          rdyLevel = 1'b1;

  always #5 clk = ~clk;

  sorting_kv #(.DWIDTH(DW), .KWIDTH(KW), .AWIDTH(AW)) dut (
    .clk_i(clk), .arst_i(arst), .data_i(dataIn), .sop_i(sopIn), .eop_i(eopIn),
    .val_i(valIn), .desc_i(descIn), .data_o(dataOut), .sop_o(sopOut),
    .eop_o(eopOut), .val_o(valOut), .ready_i(readyIn), .busy_o(busyOut),
    .ovf_o(ovfOut)
  );

  // Compares one observed value against its bench-computed expectation.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Drives one input beat for one clock cycle.
  task automatic applyStimulus(input logic [31:0] w, input logic s, input logic e, input logic d);
    dataIn = w;
    sopIn  = s;
    eopIn  = e;
    descIn = d;
    valIn  = 1'b1;
    @(posedge clk);
    #1;
    valIn = 1'b0;
    sopIn = 1'b0;
    eopIn = 1'b0;
  endtask

  task automatic sendPacket(input logic d, input bit withEop);
    for (int i = 0; i < pktQ.size(); i++) begin
      applyStimulus(pktQ[i], i == 0, withEop && (i == pktQ.size() - 1), d);
    end
  endtask

  task automatic clearRx();
    rxData.delete();
    rxSop.delete();
    rxEop.delete();
    rxCycle.delete();
    rxEopSeen = 1'b0;
  endtask

  // Stable reference: insertion sort that shifts only strictly-ordered words.
  task automatic buildExpected(input logic d);
    int n;
    int j;
    logic [31:0] x;
    expQ.delete();
    n = (pktQ.size() > 256) ? 256 : pktQ.size();
    for (int i = 0; i < n; i++) begin
      x = pktQ[i];
      j = expQ.size();
      expQ.push_back(x);
      while (j > 0 && (d ? (expQ[j-1][31:16] < x[31:16]) : (expQ[j-1][31:16] > x[31:16]))) begin
        expQ[j] = expQ[j-1];
        j--;
      end
      expQ[j] = x;
    end
  endtask

  // Waits for the eop beat to transfer, then checks that busy has dropped.
  task automatic waitDone(input string tag, input int maxCycles);
    int n;
    n = 0;
    while (!rxEopSeen && n < maxCycles) begin
      @(posedge clk);
      #2;
      n++;
    end
    checkOutput({tag, "_done"}, rxEopSeen, 1);
    checkOutput({tag, "_busyLow"}, busyOut, 0);
  endtask

  task automatic checkPacket(input string tag);
    checkOutput({tag, "_count"}, rxData.size(), expQ.size());
    for (int i = 0; i < expQ.size() && i < rxData.size(); i++) begin
      checkOutput($sformatf("%s_data%0d", tag, i), rxData[i], expQ[i]);
      checkOutput($sformatf("%s_sop%0d", tag, i), rxSop[i], i == 0);
      checkOutput($sformatf("%s_eop%0d", tag, i), rxEop[i], i == expQ.size() - 1);
    end
  endtask

  task automatic checkSpan(input string tag, input int n);
    if (rxCycle.size() > 0) begin
      checkOutput({tag, "_span"}, rxCycle[rxCycle.size()-1] - rxCycle[0], n - 1);
    end
  endtask

  task automatic loadSmall();
    pktQ = '{32'h0009_0000, 32'h0003_0001, 32'h0007_0002, 32'h0003_0003, 32'h0001_0004};
  endtask

  // Output monitor. It samples on the falling edge and records every beat
  // that transfers at the next rising edge.
  always @(negedge clk) begin
    cycleCnt++;
    if (arst !== 1'b1) begin
      if (ovfOut === 1'b1) ovfCount++;
      if (valOut === 1'b1 && readyIn === 1'b1) begin
        rxData.push_back(dataOut);
        rxSop.push_back(sopOut);
        rxEop.push_back(eopOut);
        rxCycle.push_back(cycleCnt);
        if (eopOut === 1'b1) rxEopSeen = 1'b1;
      end
    end
  end

  // Ready driver: a fixed level, or high about 30% of cycles.
  initial begin
    readyIn = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      readyIn = rdyRandom ? ($urandom_range(0, 99) < 30) : rdyLevel;
    end
  end

  initial begin
    #800000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int n;

    // Reset state
    #1 arst = 1'b1;
    #2;
    checkOutput("rst_val", valOut, 0);
    checkOutput("rst_sop", sopOut, 0);
    checkOutput("rst_eop", eopOut, 0);
    checkOutput("rst_data", dataOut, 0);
    checkOutput("rst_busy", busyOut, 0);
    checkOutput("rst_ovf", ovfOut, 0);
    @(posedge clk);
    @(posedge clk);
    #1 arst = 1'b0;

    // Ascending, stable; an extra packet sent while busy is ignored
    $display("[TB] ascending 5-word packet");
    clearRx();
    loadSmall();
    sendPacket(1'b0, 1'b1);
    #1;
    checkOutput("asc_busyHigh", busyOut, 1);
    #1;
    applyStimulus(32'h1234_5678, 1'b1, 1'b1, 1'b0);
    waitDone("asc", 200);
    expQ = '{32'h0001_0004, 32'h0003_0001, 32'h0003_0003, 32'h0007_0002, 32'h0009_0000};
    checkPacket("asc");
    checkSpan("asc", 5);
    repeat (20) @(posedge clk);
    #2;
    checkOutput("busyIgnored_count", rxData.size(), 5);
    checkOutput("busyIgnored_busy", busyOut, 0);

    // Descending, stable
    $display("[TB] descending 5-word packet");
    clearRx();
    loadSmall();
    @(posedge clk);
    #1;
    sendPacket(1'b1, 1'b1);
    waitDone("desc", 200);
    expQ = '{32'h0009_0000, 32'h0007_0002, 32'h0003_0001, 32'h0003_0003, 32'h0001_0004};
    checkPacket("desc");

    // Single-word packet
    $display("[TB] single-word packet");
    clearRx();
    applyStimulus(32'hDEAD_BEEF, 1'b1, 1'b1, 1'b0);
    #1;
    n = 0;
    while (valOut !== 1'b1 && n < 20) begin
      @(posedge clk);
      #2;
      n++;
    end
    checkOutput("single_latency", n <= 10, 1);
    waitDone("single", 50);
    expQ = '{32'hDEAD_BEEF};
    checkPacket("single");

    // Restart with sop mid-load, with gap cycles; order re-latched as ascending
    $display("[TB] sop restart mid-load");
    clearRx();
    @(posedge clk);
    #1;
    applyStimulus(32'h0050_00AA, 1'b1, 1'b0, 1'b1);
    applyStimulus(32'h0060_00BB, 1'b0, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    applyStimulus(32'h0070_00CC, 1'b0, 1'b0, 1'b1);
    applyStimulus(32'h0005_0001, 1'b1, 1'b0, 1'b0);
    applyStimulus(32'h0002_0002, 1'b0, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    applyStimulus(32'h0005_0003, 1'b0, 1'b0, 1'b1);
    applyStimulus(32'h0001_0004, 1'b0, 1'b1, 1'b1);
    waitDone("restart", 200);
    expQ = '{32'h0001_0004, 32'h0002_0002, 32'h0005_0001, 32'h0005_0003};
    checkPacket("restart");

    // Random keys, ascending, random backpressure
    $display("[TB] random 40-word ascending with backpressure");
    clearRx();
    rdyRandom = 1'b1;
    pktQ.delete();
    for (int i = 0; i < 40; i++) pktQ.push_back({16'($urandom_range(0, 7)), 16'(i)});
    buildExpected(1'b0);
    sendPacket(1'b0, 1'b1);
    waitDone("rand_asc", 4000);
    checkPacket("rand_asc");

    // Random keys, descending, random backpressure
    $display("[TB] random 24-word descending with backpressure");
    clearRx();
    pktQ.delete();
    for (int i = 0; i < 24; i++) pktQ.push_back({16'($urandom_range(0, 3)), 16'(i + 100)});
    buildExpected(1'b1);
    sendPacket(1'b1, 1'b1);
    waitDone("rand_desc", 3000);
    checkPacket("rand_desc");
    rdyRandom = 1'b0;
    rdyLevel = 1'b1;

    // Full packet of 256 words with eop on the last one: no overflow
    $display("[TB] full 256-word packet");
    clearRx();
    @(posedge clk);
    #1;
    ovfCount = 0;
    pktQ.delete();
    pktQ.push_back(32'hFFFF_0000);
    for (int i = 1; i < 256; i++) pktQ.push_back({16'(i), 16'(i)});
    buildExpected(1'b0);
    sendPacket(1'b0, 1'b1);
    waitDone("full", 5000);
    checkPacket("full");
    checkSpan("full", 256);
    checkOutput("full_ovfCount", ovfCount, 0);

    // 300 words without eop: truncated to 256 words, one overflow pulse
    $display("[TB] 300-word overflow packet");
    clearRx();
    ovfCount = 0;
    pktQ.delete();
    pktQ.push_back(32'hFFFE_0000);
    for (int i = 1; i < 300; i++) pktQ.push_back({16'(i), 16'(i)});
    buildExpected(1'b0);
    sendPacket(1'b0, 1'b0);
    waitDone("ovf", 5000);
    checkPacket("ovf");
    checkOutput("ovf_ovfCount", ovfCount, 1);

    // Reset in the middle of output while stalled, then a clean packet
    $display("[TB] reset during output");
    clearRx();
    rdyLevel = 1'b0;
    loadSmall();
    sendPacket(1'b0, 1'b1);
    #1;
    n = 0;
    while (valOut !== 1'b1 && n < 100) begin
      @(posedge clk);
      #2;
      n++;
    end
    checkOutput("rstMid_valid", valOut, 1);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #2;
      checkOutput("stall_data", dataOut, 32'h0001_0004);
      checkOutput("stall_sop", sopOut, 1);
      checkOutput("stall_val", valOut, 1);
    end
    arst = 1'b1;
    #1;
    checkOutput("rstMid_val", valOut, 0);
    checkOutput("rstMid_sop", sopOut, 0);
    checkOutput("rstMid_eop", eopOut, 0);
    checkOutput("rstMid_data", dataOut, 0);
    checkOutput("rstMid_busy", busyOut, 0);
    checkOutput("rstMid_ovf", ovfOut, 0);
    @(posedge clk);
    #1 arst = 1'b0;
    clearRx();
    rdyLevel = 1'b1;
    @(posedge clk);
    #1;
    loadSmall();
    sendPacket(1'b1, 1'b1);
    waitDone("afterRst", 200);
    expQ = '{32'h0009_0000, 32'h0007_0002, 32'h0003_0001, 32'h0003_0003, 32'h0001_0004};
    checkPacket("afterRst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
